// File: rtl/adc_scan_pkg.sv
// Shared types and defaults for the ADC scan controller.
package adc_scan_pkg;

   localparam int CLK_DIV_DEF     = 25;
   localparam int START_CYC_DEF   = 50;
   localparam int OE_CYC_DEF      = 10;
   localparam int TIMEOUT_CYC_DEF = 8192;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_WAIT_LO,
      ST_WAIT_HI,
      ST_READ,
      ST_NEXT
   } state_t;

   // Lowest set mask bit at index >= i_from. Result bit 3 = found, [2:0] = index.
   // i_from = 8 means "above channel 7" and always returns not-found.
   function automatic logic [3:0] f_next_bit(input logic [7:0] i_mask, input logic [3:0] i_from);
      logic [3:0] w_res;
      w_res = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (i_mask[i] && (i >= int'(i_from))) w_res = {1'b1, 3'(i)};
      end
      return w_res;
   endfunction

endpackage

// File: rtl/adc_clk_div.sv
// Free-running converter clock: toggles every CLK_DIV system clocks.
module adc_clk_div
   import adc_scan_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
)(
   input  logic clk,
   input  logic reset,
   output logic o_adc_clk
);

   logic [7:0] r_cnt;
   logic       r_adc_clk;

   // Count CLK_DIV cycles per half-period, then flip the output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_adc_clk <= 1'b0;
      end else if (r_cnt == 8'(CLK_DIV - 1)) begin
         r_cnt     <= '0;
         r_adc_clk <= ~r_adc_clk;
      end else begin
         r_cnt     <= r_cnt + 8'd1;
      end
   end

   assign o_adc_clk = r_adc_clk;

endmodule

// File: rtl/adc_scan_ctrl.sv
// Scan sequencer for an 8-channel ADC0808-style converter: selects each
// enabled channel in turn, pulses ALE/START, waits out EOC low/high with
// per-phase timeouts, reads the result and keeps per-channel sticky flags.
module adc_scan_ctrl
   import adc_scan_pkg::*;
#(
   parameter int CLK_DIV     = CLK_DIV_DEF,
   parameter int START_CYC   = START_CYC_DEF,
   parameter int OE_CYC      = OE_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_enable,
   input  logic [7:0]  i_chan_mask,
   input  logic        i_err_clr,
   input  logic        i_adc_eoc,
   input  logic [7:0]  i_adc_data,
   output logic        o_adc_clk,
   output logic        o_adc_ale,
   output logic        o_adc_start,
   output logic        o_adc_oe,
   output logic [2:0]  o_adc_sel,
   output logic [63:0] o_ch_data,
   output logic [7:0]  o_ch_valid,
   output logic [7:0]  o_ch_err,
   output logic        o_busy,
   output logic        o_scan_done
);

   localparam logic [31:0] START_LAST = 32'(START_CYC - 1);
   localparam logic [31:0] OE_LAST    = 32'(OE_CYC - 1);
   localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYC - 1);

   state_t      r_state, w_state_nxt;
   logic [31:0] r_cnt, w_cnt_nxt;
   logic [2:0]  r_sel, w_sel_nxt;
   logic        r_eoc_s1, r_eoc_s2;
   logic [63:0] r_ch_data;
   logic [7:0]  r_ch_valid, r_ch_err;
   logic        r_scan_done;
   logic        w_capture, w_timeout, w_done;
   logic [3:0]  w_lowest, w_above;

   adc_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk       (clk),
      .reset     (reset),
      .o_adc_clk (o_adc_clk)
   );

   // Candidates for the next channel; "above" uses the live mask so mask edits take effect mid-scan.
   assign w_lowest = f_next_bit(i_chan_mask, 4'd0);
   assign w_above  = f_next_bit(i_chan_mask, {1'b0, r_sel} + 4'd1);

   // Two-flop synchronizer for the asynchronous EOC line.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_eoc_s1 <= 1'b0;
         r_eoc_s2 <= 1'b0;
      end else begin
         r_eoc_s1 <= i_adc_eoc;
         r_eoc_s2 <= r_eoc_s1;
      end
   end

   // Next-state, phase counter and channel selection.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sel_nxt   = r_sel;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (i_enable && w_lowest[3]) begin
               w_sel_nxt   = w_lowest[2:0];
               w_state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PULSE;
         end
         ST_PULSE: begin
            if (r_cnt == START_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_WAIT_LO;
            end else w_cnt_nxt = r_cnt + 32'd1;
         end
         ST_WAIT_LO: begin
            if (!r_eoc_s2) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_WAIT_HI;
            end else if (r_cnt == TO_LAST) begin
               w_cnt_nxt   = '0;
               w_timeout   = 1'b1;
               w_state_nxt = ST_NEXT;
            end else w_cnt_nxt = r_cnt + 32'd1;
         end
         ST_WAIT_HI: begin
            if (r_eoc_s2) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_READ;
            end else if (r_cnt == TO_LAST) begin
               w_cnt_nxt   = '0;
               w_timeout   = 1'b1;
               w_state_nxt = ST_NEXT;
            end else w_cnt_nxt = r_cnt + 32'd1;
         end
         ST_READ: begin
            if (r_cnt == OE_LAST) begin
               w_cnt_nxt   = '0;
               w_capture   = 1'b1;
               w_state_nxt = ST_NEXT;
            end else w_cnt_nxt = r_cnt + 32'd1;
         end
         ST_NEXT: begin
            w_cnt_nxt = '0;
            // Wrapping past the top set bit ends a pass, even when we stop here.
            w_done    = !w_above[3];
            if (!i_enable || !w_lowest[3]) begin
               w_state_nxt = ST_IDLE;
            end else if (w_above[3]) begin
               w_sel_nxt   = w_above[2:0];
               w_state_nxt = ST_SETUP;
            end else begin
               w_sel_nxt   = w_lowest[2:0];
               w_state_nxt = ST_SETUP;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register plus counter and channel select.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_sel   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sel   <= w_sel_nxt;
      end
   end

   // Result registers and sticky flags; a same-cycle timeout overrides err_clr for its bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ch_data   <= '0;
         r_ch_valid  <= '0;
         r_ch_err    <= '0;
         r_scan_done <= 1'b0;
      end else begin
         r_scan_done <= w_done;
         if (w_capture) begin
            r_ch_data[8*r_sel +: 8] <= i_adc_data;
            r_ch_valid[r_sel]       <= 1'b1;
         end
         r_ch_err <= (i_err_clr ? 8'd0 : r_ch_err) | (w_timeout ? (8'd1 << r_sel) : 8'd0);
      end
   end

   assign o_adc_ale   = (r_state == ST_PULSE);
   assign o_adc_start = (r_state == ST_PULSE);
   assign o_adc_oe    = (r_state == ST_READ);
   assign o_adc_sel   = r_sel;
   assign o_ch_data   = r_ch_data;
   assign o_ch_valid  = r_ch_valid;
   assign o_ch_err    = r_ch_err;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_scan_done = r_scan_done;

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 25: adc_clk half-period in clk cycles, giving 1 MHz at 50 MHz clk; legal 1..255.
REQ-002 Parameter START_CYC, default 50: ALE/START pulse width in clk cycles; legal >= 1.
REQ-003 Parameter OE_CYC, default 10: adc_oe hold before data capture; legal >= 1.
REQ-004 Parameter TIMEOUT_CYC, default 8192: maximum wait per EOC phase.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 enable  in  1  level; 1 = run continuous scans.
REQ-008 chan_mask  in  8  bit N=1 includes channel N in the scan.
REQ-009 err_clr  in  1  one-cycle pulse; clears ch_err.
REQ-010 adc_eoc  in  1  converter end-of-conversion, asynchronous.
REQ-011 adc_data  in  8  converter output bus, valid while adc_oe=1.
REQ-012 adc_clk  out  1  converter clock.
REQ-013 adc_ale / adc_start  out  1 each  address latch and conversion start.
REQ-014 adc_oe  out  1  converter output enable.
REQ-015 adc_sel  out  3  converter mux address.
REQ-016 ch_data  out  64  channel N result at [8N+7:8N].
REQ-017 ch_valid / ch_err  out  8 each  sticky per-channel flags.
REQ-018 busy  out  1  FSM not in IDLE; scan_done  out  1  one-cycle pulse.

Function
REQ-019 adc_clk SHALL toggle every CLK_DIV clk cycles; it runs freely, independent of FSM state and enable.
REQ-020 adc_eoc SHALL pass through a 2-FF synchronizer; the FSM uses only the synchronized value (2-cycle latency).
REQ-021 FSM states: IDLE, SETUP, PULSE, WAIT_LO, WAIT_HI, READ, NEXT.
REQ-022 IDLE: when enable=1 and chan_mask!=0, load the lowest set mask bit into adc_sel and go to SETUP.
REQ-023 SETUP: hold adc_sel for 1 cycle, then go to PULSE.
REQ-024 PULSE: drive adc_ale=adc_start=1 for exactly START_CYC cycles, then go to WAIT_LO.
REQ-025 WAIT_LO: wait for sync EOC=0, then go to WAIT_HI; WAIT_HI: wait for sync EOC=1, then go to READ.
REQ-026 Each wait SHALL have its own TIMEOUT_CYC counter. On expiry: set ch_err[sel], leave ch_data and ch_valid unchanged, and go to NEXT.
REQ-027 READ: adc_oe=1 for OE_CYC cycles. On the last cycle: capture adc_data into ch_data[sel] and set ch_valid[sel]. adc_oe drops in the following cycle.
REQ-028 NEXT: select the next set mask bit above sel, using the current chan_mask, then go to SETUP.
  - No set bit above sel: pulse scan_done and restart from the lowest set bit. This is the wrap case.
  - enable=0 or chan_mask=0 at this point: go to IDLE instead; scan_done still pulses if the scan wrapped.
REQ-029 Dropping enable mid-conversion SHALL NOT abort it: the current channel completes (or times out) before IDLE.
REQ-030 A single-bit mask SHALL reconvert that channel every pass, with a scan_done pulse on each pass.
REQ-031 err_clr clears all ch_err bits. If a timeout lands in the same cycle, the timeout bit wins.
REQ-032 adc_sel SHALL stay stable from SETUP through the end of READ.

Reset
REQ-033 Reset values: FSM=IDLE; adc_clk, adc_ale, adc_start, adc_oe = 0; adc_sel=0; ch_data=0; ch_valid=0; ch_err=0; busy=0; scan_done=0; all counters and synchronizer flops = 0.
REQ-034 Reset asserted mid-operation SHALL abort immediately, with outputs at reset values on the next edge.

Structure
REQ-035 Package adc_scan_pkg SHALL hold:
  - the FSM state enum;
  - parameter defaults;
  - a helper function returning the next set mask bit index.
REQ-036 Sub-module adc_clk_div SHALL implement REQ-019. All other logic is a single FSM module.

Verification
REQ-037 Reset: drive reset=1 for 3 cycles with enable=1 -> all outputs 0, busy=0.
REQ-038 Full scan: mask=0xFF; converter model returns 0x10+N for channel N, EOC low 10 cycles after START, high 500 cycles later.
  - Expect adc_sel order 0..7.
  - Expect ch_data=0x17161514_13121110, ch_valid=0xFF, then one scan_done pulse and restart at channel 0.
REQ-039 Sparse mask: mask=0x81 -> sequence 0,7,0,7; a scan_done pulse after each channel-7 read.
REQ-040 Timeout: with TIMEOUT_CYC=64, model never drops EOC on channel 2, mask=0x04.
  - Expect ch_err=0x04, ch_valid=0x00, conversion retried.
  - Then err_clr -> ch_err=0.
REQ-041 Enable drop: deassert enable during WAIT_HI of channel 3 -> channel 3 captured, then IDLE, busy=0, no further adc_start.
REQ-042 Timing: measure adc_start high = START_CYC cycles, adc_oe high = OE_CYC cycles, adc_clk period = 2*CLK_DIV cycles; adc_sel stable while adc_oe=1.
